// File: rtl/mem_ctrl_pkg.sv
// Shared types for the external RAM port controller: FSM encodings, access lengths
// and the buffered load/store request.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      MC_IDLE  = 2'b00,
      MC_IF_RD = 2'b01,
      MC_LS_RD = 2'b10,
      MC_LS_WR = 2'b11
   } mc_state_e;

   localparam logic [1:0] LEN_BYTE = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_WORD = 2'b10;

   typedef struct packed {
      logic        ls;
      logic [1:0]  len;
      logic [31:0] addr;
      logic [31:0] val;
   } lsb_op_t;

   function automatic logic [2:0] len_bytes(input logic [1:0] len);
      logic [2:0] n;
      case (len)
         LEN_BYTE: n = 3'd1;
         LEN_HALF: n = 3'd2;
         default:  n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte-serial sequencer: walks n consecutive byte addresses, shifting write data out
// and assembling read data from the one-cycle-late RAM return byte.
module mem_byte_seq (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        en,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] start_addr,
   input  logic [31:0] start_val,
   input  logic [2:0]  start_n,
   input  logic        start_wr,
   input  logic        stall,
   input  logic [7:0]  mem_din,
   output logic [31:0] mem_a,
   output logic [7:0]  mem_dout,
   output logic        wr_drive,
   output logic        last,
   output logic [31:0] data_next
);

   logic        act_q;
   logic        wr_q;
   logic [2:0]  cnt_q;
   logic [2:0]  n_q;
   logic [31:0] addr_q;
   logic [31:0] sval_q;
   logic [31:0] data_q;
   logic        drive;
   logic [1:0]  byte_idx;

   always_comb begin
      drive     = act_q && (cnt_q < n_q);
      mem_a     = drive ? addr_q : 32'd0;
      mem_dout  = (drive && wr_q) ? sval_q[7:0] : 8'd0;
      wr_drive  = drive && wr_q && !stall;
      // Writes end on the last byte driven; reads need one more cycle for the return byte.
      last      = act_q && (wr_q ? ((cnt_q == n_q - 3'd1) && !stall) : (cnt_q == n_q));
      byte_idx  = 2'(cnt_q - 3'd1);
      data_next = data_q;
      if (act_q && !wr_q && (cnt_q != 3'd0)) begin
         data_next[{byte_idx, 3'b000} +: 8] = mem_din;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         act_q  <= 1'b0;
         wr_q   <= 1'b0;
         cnt_q  <= 3'd0;
         n_q    <= 3'd0;
         addr_q <= 32'd0;
         sval_q <= 32'd0;
         data_q <= 32'd0;
      end else if (en) begin
         if (abort) begin
            act_q <= 1'b0;
            cnt_q <= 3'd0;
         end else if (start) begin
            act_q  <= 1'b1;
            wr_q   <= start_wr;
            cnt_q  <= 3'd0;
            n_q    <= start_n;
            addr_q <= start_addr;
            sval_q <= start_val;
            data_q <= 32'd0;
         end else if (act_q && !stall) begin
            data_q <= data_next;
            if (last) begin
               act_q <= 1'b0;
            end else begin
               cnt_q  <= cnt_q + 3'd1;
               addr_q <= addr_q + 32'd1;
               sval_q <= sval_q >> 8;
            end
         end
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// External RAM port controller: arbitrates fetch and load/store requests, holds one
// pending LSB request, and runs the byte sequencer for each granted access.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned POS_W    = 4,
   parameter int unsigned IF_BYTES = 4,
   parameter logic [1:0]  IO_BASE  = 2'b11
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             clear,
   input  logic             io_buffer_full,
   input  logic [7:0]       mem_din,
   output logic [7:0]       mem_dout,
   output logic [31:0]      mem_a,
   output logic             mem_wr,
   input  logic             if_req,
   input  logic [31:0]      if_addr,
   output logic             if_done,
   output logic [31:0]      if_data,
   input  logic             lsb_req,
   input  logic [POS_W-1:0] lsb_pos,
   input  logic             lsb_ls,
   input  logic [1:0]       lsb_len,
   input  logic [31:0]      lsb_addr,
   input  logic [31:0]      lsb_val,
   output logic             lsb_busy,
   output logic             lsb_finished,
   output logic [POS_W-1:0] lsb_pos_out,
   output logic [31:0]      lsb_val_out
);

   mc_state_e        state_q, state_d;
   logic             pend_v_q, pend_v_d;
   lsb_op_t          pend_op_q, pend_op_d;
   logic [POS_W-1:0] pend_pos_q, pend_pos_d;
   logic [POS_W-1:0] cur_pos_q, cur_pos_d;
   logic             wr_clr_q, wr_clr_d;
   logic             if_done_q, if_done_d;
   logic [31:0]      if_data_q, if_data_d;
   logic             fin_q, fin_d;
   logic [POS_W-1:0] pos_out_q, pos_out_d;
   logic [31:0]      val_out_q, val_out_d;

   lsb_op_t          lsb_in;
   lsb_op_t          grant_op;
   logic             seq_start, seq_abort, seq_stall, seq_last, seq_wr_drive;
   logic [2:0]       seq_n;
   logic [31:0]      seq_data;

   assign lsb_in = '{ls: lsb_ls, len: lsb_len, addr: lsb_addr, val: lsb_val};

   // IO writes stall byte by byte while the UART buffer is full.
   assign seq_stall = (state_q == MC_LS_WR) && io_buffer_full && (mem_a[17:16] == IO_BASE);

   always_comb begin
      state_d    = state_q;
      pend_v_d   = pend_v_q;
      pend_op_d  = pend_op_q;
      pend_pos_d = pend_pos_q;
      cur_pos_d  = cur_pos_q;
      wr_clr_d   = wr_clr_q;
      if_done_d  = 1'b0;
      if_data_d  = if_data_q;
      fin_d      = 1'b0;
      pos_out_d  = pos_out_q;
      val_out_d  = val_out_q;
      grant_op   = '0;
      seq_start  = 1'b0;
      seq_abort  = 1'b0;
      seq_n      = 3'd0;

      unique case (state_q)
         MC_IDLE: begin
            if (clear) begin
               pend_v_d = 1'b0;
            end else if (pend_v_q) begin
               seq_start = 1'b1;
               grant_op  = pend_op_q;
               seq_n     = len_bytes(pend_op_q.len);
               cur_pos_d = pend_pos_q;
               pend_v_d  = 1'b0;
               state_d   = pend_op_q.ls ? MC_LS_WR : MC_LS_RD;
            end else if (lsb_req) begin
               seq_start = 1'b1;
               grant_op  = lsb_in;
               seq_n     = len_bytes(lsb_len);
               cur_pos_d = lsb_pos;
               state_d   = lsb_ls ? MC_LS_WR : MC_LS_RD;
            end else if (if_req) begin
               seq_start     = 1'b1;
               grant_op.addr = if_addr;
               seq_n         = 3'(IF_BYTES);
               state_d       = MC_IF_RD;
            end
         end
         MC_IF_RD, MC_LS_RD: begin
            if (clear) begin
               seq_abort = 1'b1;
               pend_v_d  = 1'b0;
               state_d   = MC_IDLE;
            end else if (seq_last) begin
               state_d = MC_IDLE;
               if (state_q == MC_IF_RD) begin
                  if_done_d = 1'b1;
                  if_data_d = seq_data;
               end else begin
                  fin_d     = 1'b1;
                  pos_out_d = cur_pos_q;
                  val_out_d = seq_data;
               end
            end
         end
         MC_LS_WR: begin
            // A committed store always completes; a flush only hides its completion.
            if (clear) begin
               wr_clr_d = 1'b1;
            end
            if (seq_last) begin
               state_d   = MC_IDLE;
               wr_clr_d  = 1'b0;
               fin_d     = !(wr_clr_q || clear);
               pos_out_d = cur_pos_q;
               val_out_d = 32'd0;
            end
         end
         default: state_d = MC_IDLE;
      endcase

      if (lsb_req && (state_q != MC_IDLE) && !(clear && (state_q != MC_LS_WR))) begin
         pend_v_d   = 1'b1;
         pend_op_d  = lsb_in;
         pend_pos_d = lsb_pos;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= MC_IDLE;
         pend_v_q   <= 1'b0;
         pend_op_q  <= '0;
         pend_pos_q <= '0;
         cur_pos_q  <= '0;
         wr_clr_q   <= 1'b0;
         if_done_q  <= 1'b0;
         if_data_q  <= 32'd0;
         fin_q      <= 1'b0;
         pos_out_q  <= '0;
         val_out_q  <= 32'd0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         pend_v_q   <= pend_v_d;
         pend_op_q  <= pend_op_d;
         pend_pos_q <= pend_pos_d;
         cur_pos_q  <= cur_pos_d;
         wr_clr_q   <= wr_clr_d;
         if_done_q  <= if_done_d;
         if_data_q  <= if_data_d;
         fin_q      <= fin_d;
         pos_out_q  <= pos_out_d;
         val_out_q  <= val_out_d;
      end
   end

   mem_byte_seq u_seq (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .en         (rdy_in),
      .start      (seq_start),
      .abort      (seq_abort),
      .start_addr (grant_op.addr),
      .start_val  (grant_op.val),
      .start_n    (seq_n),
      .start_wr   (grant_op.ls),
      .stall      (seq_stall),
      .mem_din    (mem_din),
      .mem_a      (mem_a),
      .mem_dout   (mem_dout),
      .wr_drive   (seq_wr_drive),
      .last       (seq_last),
      .data_next  (seq_data)
   );

   assign mem_wr       = seq_wr_drive && rdy_in;
   assign lsb_busy     = (state_q != MC_IDLE) || pend_v_q || lsb_req;
   assign if_done      = if_done_q;
   assign if_data      = if_data_q;
   assign lsb_finished = fin_q;
   assign lsb_pos_out  = pos_out_q;
   assign lsb_val_out  = val_out_q;

   pend_overflow_a: assert property (@(posedge clk_in) disable iff (rst_in)
      !(rdy_in && lsb_req && pend_v_q));

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl against a byte-wide RAM model with one-cycle read return.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear, io_buffer_full;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        if_req, if_done;
   logic [31:0] if_addr, if_data;
   logic        lsb_req, lsb_ls, lsb_busy, lsb_finished;
   logic [3:0]  lsb_pos, lsb_pos_out;
   logic [1:0]  lsb_len;
   logic [31:0] lsb_addr, lsb_val, lsb_val_out;

   logic [7:0]  ram [0:262143];
   int          wr_count = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   typedef struct {
      logic        ls;
      logic [1:0]  len;
      logic [31:0] addr;
      logic [31:0] val;
      logic [31:0] exp_val;
      int          exp_lat;
   } vec_t;
   vec_t vecs [9];

   mem_ctrl #(.POS_W(4), .IF_BYTES(4), .IO_BASE(2'b11)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .clear          (clear),
      .io_buffer_full (io_buffer_full),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .if_req         (if_req),
      .if_addr        (if_addr),
      .if_done        (if_done),
      .if_data        (if_data),
      .lsb_req        (lsb_req),
      .lsb_pos        (lsb_pos),
      .lsb_ls         (lsb_ls),
      .lsb_len        (lsb_len),
      .lsb_addr       (lsb_addr),
      .lsb_val        (lsb_val),
      .lsb_busy       (lsb_busy),
      .lsb_finished   (lsb_finished),
      .lsb_pos_out    (lsb_pos_out),
      .lsb_val_out    (lsb_val_out)
   );

   initial forever #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      mem_din <= ram[mem_a[17:0]];
      if (mem_wr) begin
         ram[mem_a[17:0]] = mem_dout;
         wr_count = wr_count + 1;
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_lsb(output int cyc);
      cyc = -1;
      for (int c = 0; c < 24 && cyc < 0; c++) begin
         if (lsb_finished) cyc = c;
         else step();
      end
   endtask

   task automatic wait_if(output int cyc);
      cyc = -1;
      for (int c = 0; c < 24 && cyc < 0; c++) begin
         if (if_done) cyc = c;
         else step();
      end
   endtask

   task automatic issue(input logic ls, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] val, input logic [3:0] pos);
      lsb_req  = 1'b1;
      lsb_ls   = ls;
      lsb_len  = len;
      lsb_addr = addr;
      lsb_val  = val;
      lsb_pos  = pos;
   endtask

   initial begin
      int lat;
      int wc0;
      logic saw;

      for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
      ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
      ram[32'h2000] = 8'h11; ram[32'h2001] = 8'h22; ram[32'h2002] = 8'h33; ram[32'h2003] = 8'h44;
      ram[32'h3FFFE] = 8'hAA; ram[32'h3FFFF] = 8'hBB; ram[0] = 8'hCC; ram[1] = 8'hDD;
      ram[32'h12] = 8'h77;

      vecs[0] = '{1'b0, LEN_BYTE, 32'h0000_2000, 32'h0, 32'h0000_0011, 2};
      vecs[1] = '{1'b0, LEN_HALF, 32'h0000_2001, 32'h0, 32'h0000_3322, 3};
      vecs[2] = '{1'b0, LEN_WORD, 32'h0000_2000, 32'h0, 32'h4433_2211, 5};
      vecs[3] = '{1'b1, LEN_BYTE, 32'h0000_0040, 32'hFFFF_FF5A, 32'h0, 1};
      vecs[4] = '{1'b0, LEN_HALF, 32'h0000_0040, 32'h0, 32'h0000_005A, 3};
      vecs[5] = '{1'b1, LEN_WORD, 32'h0000_0044, 32'hDEAD_BEEF, 32'h0, 4};
      vecs[6] = '{1'b0, LEN_WORD, 32'h0000_0044, 32'h0, 32'hDEAD_BEEF, 5};
      vecs[7] = '{1'b0, LEN_WORD, 32'hFFFF_FFFE, 32'h0, 32'hDDCC_BBAA, 5};
      vecs[8] = '{1'b0, LEN_HALF, 32'h0000_0045, 32'h0, 32'h0000_ADBE, 3};

      rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b0; if_addr = 32'h0;
      lsb_req = 1'b0; lsb_ls = 1'b0; lsb_len = 2'b00; lsb_addr = 32'h0; lsb_val = 32'h0;
      lsb_pos = 4'h0;
      repeat (3) step();
      check("rst_mem_a", mem_a, 32'h0);
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_if_done", 32'(if_done), 32'd0);
      check("rst_if_data", if_data, 32'h0);
      check("rst_fin", 32'(lsb_finished), 32'd0);
      check("rst_val_out", lsb_val_out, 32'h0);
      check("rst_busy", 32'(lsb_busy), 32'd0);
      rst_in = 1'b0;
      step();

      // Word fetch: four byte addresses, done in cycle 5.
      if_req = 1'b1; if_addr = 32'h100;
      step();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t1_mem_a%0d", k), mem_a, 32'h100 + 32'(k));
         check($sformatf("t1_wr%0d", k), 32'(mem_wr), 32'd0);
         check($sformatf("t1_done_early%0d", k), 32'(if_done), 32'd0);
         step();
      end
      check("t1_done_c4", 32'(if_done), 32'd0);
      step();
      check("t1_done_c5", 32'(if_done), 32'd1);
      check("t1_if_data", if_data, 32'h0000_0513);
      if_req = 1'b0;
      step();
      check("t1_done_pulse", 32'(if_done), 32'd0);
      check("t1_idle_mem_a", mem_a, 32'h0);

      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].ls, vecs[i].len, vecs[i].addr, vecs[i].val, 4'(i));
         step();
         lsb_req = 1'b0;
         wait_lsb(lat);
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_val", i), lsb_val_out, vecs[i].exp_val);
         check($sformatf("vec%0d_pos", i), 32'(lsb_pos_out), 32'(i));
      end
      step();

      // LSB beats a simultaneous fetch; fetch granted right after the LSB finishes.
      if_req = 1'b1; if_addr = 32'h100;
      issue(1'b0, LEN_WORD, 32'h2000, 32'h0, 4'd3);
      step();
      lsb_req = 1'b0;
      check("t2_first_addr", mem_a, 32'h2000);
      repeat (5) step();
      check("t2_fin", 32'(lsb_finished), 32'd1);
      check("t2_pos", 32'(lsb_pos_out), 32'd3);
      check("t2_val", lsb_val_out, 32'h4433_2211);
      step();
      check("t2_fetch_addr", mem_a, 32'h100);
      wait_if(lat);
      check("t2_if_lat", 32'(lat), 32'd5);
      check("t2_if_data", if_data, 32'h0000_0513);
      if_req = 1'b0;
      step();

      // Half store.
      issue(1'b1, LEN_HALF, 32'h10, 32'hABCD_1234, 4'd1);
      step();
      lsb_req = 1'b0;
      check("t3_a0", mem_a, 32'h10);
      check("t3_wr0", 32'(mem_wr), 32'd1);
      check("t3_d0", 32'(mem_dout), 32'h34);
      step();
      check("t3_a1", mem_a, 32'h11);
      check("t3_wr1", 32'(mem_wr), 32'd1);
      check("t3_d1", 32'(mem_dout), 32'h12);
      step();
      check("t3_fin", 32'(lsb_finished), 32'd1);
      check("t3_val0", lsb_val_out, 32'h0);
      check("t3_wr_idle", 32'(mem_wr), 32'd0);
      check("t3_ram", {8'h0, ram[32'h12], ram[32'h11], ram[32'h10]}, 32'h0077_1234);
      step();

      // IO store held off by a full UART buffer for three cycles.
      wc0 = wr_count;
      io_buffer_full = 1'b1;
      issue(1'b1, LEN_BYTE, 32'h30000, 32'h41, 4'd2);
      step();
      lsb_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t4_stall_wr%0d", k), 32'(mem_wr), 32'd0);
         check($sformatf("t4_stall_a%0d", k), mem_a, 32'h30000);
         check($sformatf("t4_stall_fin%0d", k), 32'(lsb_finished), 32'd0);
         step();
      end
      io_buffer_full = 1'b0;
      #1;
      check("t4_wr", 32'(mem_wr), 32'd1);
      check("t4_dout", 32'(mem_dout), 32'h41);
      step();
      check("t4_fin", 32'(lsb_finished), 32'd1);
      check("t4_wr_count", 32'(wr_count - wc0), 32'd1);
      check("t4_ram", 32'(ram[32'h30000]), 32'h41);
      step();

      // Flush aborts a word load; no completion, then a fresh fetch runs.
      issue(1'b0, LEN_WORD, 32'h2000, 32'h0, 4'd6);
      step();
      lsb_req = 1'b0;
      step();
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("t5_idle_a", mem_a, 32'h0);
      check("t5_idle_busy", 32'(lsb_busy), 32'd0);
      saw = 1'b0;
      for (int k = 0; k < 6; k++) begin
         saw = saw | lsb_finished;
         step();
      end
      check("t5_no_fin", 32'(saw), 32'd0);
      if_req = 1'b1; if_addr = 32'h100;
      step();
      wait_if(lat);
      check("t5_if_lat", 32'(lat), 32'd5);
      check("t5_if_data", if_data, 32'h0000_0513);
      if_req = 1'b0;
      step();

      // LSB request during a fetch waits in the pend slot.
      if_req = 1'b1; if_addr = 32'h100;
      step();
      for (int c = 0; c <= 8; c++) begin
         if (c == 1) issue(1'b0, LEN_BYTE, 32'h2000, 32'h0, 4'd5);
         else lsb_req = 1'b0;
         #1;
         if (c < 8) check($sformatf("t6_busy%0d", c), 32'(lsb_busy), 32'd1);
         if (c == 5) begin
            check("t6_if_done", 32'(if_done), 32'd1);
            if_req = 1'b0;
         end
         if (c == 6) check("t6_pend_addr", mem_a, 32'h2000);
         if (c == 8) begin
            check("t6_fin", 32'(lsb_finished), 32'd1);
            check("t6_val", lsb_val_out, 32'h11);
            check("t6_pos", 32'(lsb_pos_out), 32'd5);
            check("t6_busy_end", 32'(lsb_busy), 32'd0);
         end
         if (c < 8) step();
      end
      step();

      // rdy_in low for two cycles in the middle of a word store.
      wc0 = wr_count;
      issue(1'b1, LEN_WORD, 32'h50, 32'h0102_0304, 4'd7);
      step();
      lsb_req = 1'b0;
      check("t7_d0", 32'(mem_dout), 32'h04);
      step();
      rdy_in = 1'b0;
      #1;
      check("t7_frz_wr", 32'(mem_wr), 32'd0);
      check("t7_frz_a", mem_a, 32'h51);
      step();
      check("t7_frz_a2", mem_a, 32'h51);
      step();
      rdy_in = 1'b1;
      #1;
      check("t7_resume_wr", 32'(mem_wr), 32'd1);
      check("t7_resume_d", 32'(mem_dout), 32'h03);
      wait_lsb(lat);
      check("t7_lat", 32'(lat), 32'd3);
      check("t7_ram", {ram[32'h53], ram[32'h52], ram[32'h51], ram[32'h50]}, 32'h0102_0304);
      check("t7_wr_count", 32'(wr_count - wc0), 32'd4);
      step();

      // Flush during a store: all bytes land, completion hidden.
      issue(1'b1, LEN_HALF, 32'h60, 32'h0000_BEEF, 4'd4);
      step();
      lsb_req = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("t8_wr1", 32'(mem_wr), 32'd1);
      check("t8_a1", mem_a, 32'h61);
      step();
      check("t8_no_fin", 32'(lsb_finished), 32'd0);
      check("t8_ram", {16'h0, ram[32'h61], ram[32'h60]}, 32'h0000_BEEF);
      check("t8_busy", 32'(lsb_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
